// File: rtl/eth_pkg.sv
// Shared constants and types for the 10BASE-T receive path.
// Also used by the transmit-side FCS generator.
package eth_pkg;

    localparam logic [7:0]  ETH_SFD     = 8'hD5;
    localparam logic [7:0]  ETH_PRE     = 8'h55;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    // Good-frame residue in normal (MSB-first) bit order.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    // Reflected CRC-32 polynomial for the LSB-first register.
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DATA = 2'd2,
        END  = 2'd3
    } eth_state_e;

    // Converts between reflected and normal CRC bit order.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 update, purely combinational.
// Bits are consumed LSB first, matching wire order.
module eth_crc32
    import eth_pkg::*;
(
    input  logic [31:0] i_crc_in,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_crc_out
);

    logic [31:0] w_c;

    // Eight serial LFSR steps unrolled into one cycle.
    always_comb begin
        w_c = i_crc_in ^ {24'h0, i_byte};
        for (int i = 0; i < 8; i++) begin
            if (w_c[0]) begin
                w_c = (w_c >> 1) ^ CRC_POLY;
            end else begin
                w_c = w_c >> 1;
            end
        end
        o_crc_out = w_c;
    end

endmodule

// File: rtl/eth_rx.sv
// 10BASE-T Manchester receiver: bit recovery, SFD hunt,
// byte assembly and FCS check on the oversampled line.
module eth_rx
    import eth_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int LOCKOUT      = 7,
    parameter int IDLE_CLKS    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_eth,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_crc_ok,
    output logic       out_err
);

    localparam int LW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(IDLE_CLKS + 1);

    localparam logic [LW-1:0] LOCK_INIT = LW'(LOCKOUT);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CLKS);
    localparam logic [10:0]   BYTE_MAX  = 11'd2047;

    logic [1:0]    r_sync;
    logic          r_prev;
    logic [LW-1:0] r_lock;
    logic [IW-1:0] r_idle;

    eth_state_e    r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
    logic [10:0]   r_bytecnt;
    logic [31:0]   r_crc;
    logic          r_sof_pend;
    logic          r_byte_rdy;

    logic          w_edge;
    logic          w_acc;
    logic          w_bit;
    logic          w_tmo;
    logic [7:0]    w_shift_nxt;
    logic [31:0]   w_crc_nxt;
    logic          w_aligned;
    logic          w_len_ok;
    logic          w_crc_match;

    assign w_edge      = r_sync[1] ^ r_prev;
    assign w_acc       = w_edge && (r_lock == '0);
    assign w_bit       = r_sync[1];
    // An accepted edge always beats a coincident timeout.
    assign w_tmo       = (r_idle == IDLE_MAX) && !w_acc;
    assign w_shift_nxt = {w_bit, r_shift[7:1]};
    assign w_aligned   = (r_bitcnt == 3'd0);
    assign w_len_ok    = (r_bytecnt >= 11'd4);
    // The register holds the residue in reflected order.
    assign w_crc_match = (bitrev32(r_crc) == CRC_RESIDUE);

    eth_crc32 u_crc (
        .i_crc_in  (r_crc),
        .i_byte    (r_shift),
        .o_crc_out (w_crc_nxt)
    );

    // Two-flop synchronizer plus previous sample for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx_eth};
            r_prev <= r_sync[1];
        end
    end

    // Lockout masks the cell-boundary edge after each mid-bit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= '0;
        end else if (w_acc) begin
            r_lock <= LOCK_INIT;
        end else if (r_lock != '0) begin
            r_lock <= r_lock - LW'(1);
        end
    end

    // Saturating count of clocks since the last accepted edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_acc) begin
            r_idle <= '0;
        end else if (r_idle != IDLE_MAX) begin
            r_idle <= r_idle + IW'(1);
        end
    end

    // Frame FSM with shift register, bit/byte counters and CRC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_bytecnt  <= 11'd0;
            r_crc      <= 32'h0;
            r_sof_pend <= 1'b0;
            r_byte_rdy <= 1'b0;
        end else begin
            r_byte_rdy <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_shift <= w_shift_nxt;
                        r_state <= HUNT;
                    end
                end
                HUNT: begin
                    if (w_acc) begin
                        r_shift <= w_shift_nxt;
                        if (w_shift_nxt == ETH_SFD) begin
                            r_state    <= DATA;
                            r_bitcnt   <= 3'd0;
                            r_bytecnt  <= 11'd0;
                            r_crc      <= CRC_INIT;
                            r_sof_pend <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_state <= IDLE;
                        r_shift <= 8'h00;
                    end
                end
                DATA: begin
                    if (w_acc) begin
                        r_shift  <= w_shift_nxt;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_byte_rdy <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_state <= END;
                    end
                end
                END: begin
                    r_state <= IDLE;
                    r_shift <= 8'h00;
                end
            endcase
            // A completed byte is folded into the CRC one cycle later.
            if (r_byte_rdy) begin
                r_crc      <= w_crc_nxt;
                r_sof_pend <= 1'b0;
                if (r_bytecnt != BYTE_MAX) begin
                    r_bytecnt <= r_bytecnt + 11'd1;
                end
            end
        end
    end

    // Registered byte strobe and end-of-frame status.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_crc_ok <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            out_valid  <= r_byte_rdy;
            out_sof    <= r_byte_rdy && r_sof_pend;
            if (r_byte_rdy) begin
                out_data <= r_shift;
            end
            out_eof    <= (r_state == END);
            out_crc_ok <= (r_state == END) && w_aligned
                          && w_len_ok && w_crc_match;
            out_err    <= (r_state == END)
                          && (!w_aligned || !w_len_ok);
        end
    end

endmodule

// File: tb/tb_eth_rx.sv
// Directed bench for eth_rx: Manchester line driver, frame-level
// expectation queue and a per-cycle output comparator.
`timescale 1ns/1ps
module tb_eth_rx;
    import eth_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_eth = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_sof, out_eof, out_crc_ok, out_err;

    eth_rx #(.CLKS_PER_BIT(10), .LOCKOUT(7), .IDLE_CLKS(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_eth     (rx_eth),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_crc_ok (out_crc_ok),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         eof;
        logic [7:0] data;
        bit         sof;
        bit         ok;
        bit         err;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    logic [7:0] fr[$];
    bit         bq[$];

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_sof = 0, n_eof = 0, n_ok = 0, n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Serial CRC-32 over whole bytes, LSB first (reflected form).
    function automatic logic [31:0] crc_model(input logic [7:0] d[$], input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    // Payload of npay bytes followed by its FCS, LSB byte first.
    task automatic make_frame(input int npay, input int seed);
        logic [31:0] c;
        fr = {};
        for (int i = 0; i < npay; i++) fr.push_back(8'((i * 7 + seed) & 255));
        c = ~crc_model(fr, npay);
        for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int b = 0; b < 8; b++) bq.push_back(v[b]);
    endtask

    task automatic build_bits(input int npre, input bit sfd, input int nby, input int extra);
        bq = {};
        repeat (npre) push_byte(ETH_PRE);
        if (sfd) push_byte(ETH_SFD);
        for (int i = 0; i < nby; i++) push_byte(fr[i]);
        for (int e = 0; e < extra; e++) bq.push_back(e[0]);
    endtask

    // Expected outputs for a frame of nby bytes plus dribble bits.
    task automatic expect_frame(input int nby, input int extra);
        ev_t         e;
        logic [31:0] c, fcs;
        for (int i = 0; i < nby; i++) begin
            e.eof = 0; e.data = fr[i]; e.sof = (i == 0); e.ok = 0; e.err = 0;
            exp_q.push_back(e);
        end
        e.eof = 1; e.data = 8'h00; e.sof = 0;
        e.err = (extra != 0) || (nby < 4);
        e.ok  = 0;
        if (!e.err) begin
            c   = ~crc_model(fr, nby - 4);
            fcs = {fr[nby-1], fr[nby-2], fr[nby-3], fr[nby-4]};
            e.ok = (c == fcs);
        end
        exp_q.push_back(e);
    endtask

    // Manchester: 1 = low then high, 0 = high then low; idle low.
    task automatic drive(input int jit);
        int j;
        foreach (bq[k]) begin
            j = (jit > 0) ? (int'($urandom_range(0, 2 * jit)) - jit) : 0;
            rx_eth = ~bq[k];
            #(50 + j);
            rx_eth = bq[k];
            #(50 - j);
        end
        rx_eth = 1'b0;
    endtask

    task automatic settle();
        repeat (60) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Compare every strobe against the head of the expectation queue.
    always @(negedge clk) begin
        if (out_valid === 1'b1 || out_eof === 1'b1) begin
            chk("valid_eof_exclusive", out_valid & out_eof, 0);
            n_valid += int'(out_valid);
            n_sof   += int'(out_valid & out_sof);
            n_eof   += int'(out_eof);
            n_ok    += int'(out_eof & out_crc_ok);
            n_err   += int'(out_eof & out_err);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b eof=%0b data=%02h, none expected at %0t",
                         out_valid, out_eof, out_data, $time);
            end else begin
                ev = exp_q.pop_front();
                if (ev.eof) begin
                    chk("eof", out_eof, 1);
                    chk("crc_ok", out_crc_ok, ev.ok);
                    chk("err", out_err, ev.err);
                end else begin
                    chk("valid", out_valid, 1);
                    chk("data", out_data, ev.data);
                    chk("sof", out_sof, ev.sof);
                end
            end
        end
    end

    initial begin
        int v0, s0, e0, o0, r0;
        logic [31:0] c;

        repeat (4) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_eof", out_eof, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_crc_ok", out_crc_ok, 0);
        chk("rst_err", out_err, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Pin the CRC model: CRC-32 of "123456789".
        fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = ~crc_model(fr, 9);
        chk("crc_model_check", c, 32'hCBF43926);

        // 64-byte frame: 60 payload + 4 FCS.
        v0 = n_valid; s0 = n_sof; e0 = n_eof; o0 = n_ok;
        make_frame(60, 3);
        build_bits(7, 1, 64, 0);
        expect_frame(64, 0);
        drive(0);
        settle();
        chk("loop_valid_cnt", n_valid - v0, 64);
        chk("loop_sof_cnt", n_sof - s0, 1);
        chk("loop_eof_cnt", n_eof - e0, 1);
        chk("loop_ok_cnt", n_ok - o0, 1);

        // One flipped payload bit.
        e0 = n_eof; o0 = n_ok; r0 = n_err;
        make_frame(20, 11);
        fr[5] = fr[5] ^ 8'h10;
        build_bits(7, 1, 24, 0);
        expect_frame(24, 0);
        drive(0);
        settle();
        chk("corrupt_eof_cnt", n_eof - e0, 1);
        chk("corrupt_ok_cnt", n_ok - o0, 0);
        chk("corrupt_err_cnt", n_err - r0, 0);

        // Preamble without SFD.
        v0 = n_valid; e0 = n_eof;
        build_bits(7, 0, 0, 0);
        drive(0);
        settle();
        chk("pre_only_valid", n_valid - v0, 0);
        chk("pre_only_eof", n_eof - e0, 0);

        // Normal link pulses on an idle line.
        v0 = n_valid; e0 = n_eof;
        repeat (4) begin
            rx_eth = 1'b1;
            #100;
            rx_eth = 1'b0;
            #2000;
        end
        settle();
        chk("nlp_valid", n_valid - v0, 0);
        chk("nlp_eof", n_eof - e0, 0);

        // Truncated: 3 bits past a byte boundary.
        o0 = n_ok; r0 = n_err;
        make_frame(10, 29);
        build_bits(7, 1, 14, 3);
        expect_frame(14, 3);
        drive(0);
        settle();
        chk("trunc_err_cnt", n_err - r0, 1);
        chk("trunc_ok_cnt", n_ok - o0, 0);

        // Reset pulse inside the 4th payload byte, then a clean frame.
        v0 = n_valid; e0 = n_eof; o0 = n_ok;
        fr = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        build_bits(7, 1, 6, 0);
        for (int i = 0; i < 3; i++) begin
            ev.eof = 0; ev.data = 8'h00; ev.sof = (i == 0); ev.ok = 0; ev.err = 0;
            exp_q.push_back(ev);
        end
        fork
            drive(0);
            begin
                #((64 + 28) * 100);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        settle();
        chk("rst_abort_valid", n_valid - v0, 3);
        chk("rst_abort_eof", n_eof - e0, 0);
        make_frame(12, 41);
        build_bits(7, 1, 16, 0);
        expect_frame(16, 0);
        drive(0);
        settle();
        chk("after_rst_eof", n_eof - e0, 1);
        chk("after_rst_ok", n_ok - o0, 1);

        // Phase sweep with jittered mid-bit edges, same frame each time.
        o0 = n_ok;
        for (int p = 0; p < 10; p++) begin
            make_frame(14, 5);
            build_bits(7, 1, 18, 0);
            expect_frame(18, 0);
            #(p * 10 + 3);
            drive(9);
            settle();
        end
        chk("sweep_ok_cnt", n_ok - o0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
